// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared opcode/funct constants, state enum and datapath control encodings.
// Define MULTICYCLE_CONTROL_JUMP_EN to include the JUMP state.
package mc_ctrl_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB
`ifdef MULTICYCLE_CONTROL_JUMP_EN
        , S_JUMP
`endif
    } state_t;
endpackage

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder: maps ALUOp and funct to an ALU control code, flagging unknown R-type funct.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alucontrol_o,
    output logic       illegal_o
);
    logic [2:0] fn_alu;
    logic       known;
    assign fn_alu = funct_i == F_ADD ? ALU_ADD :
                    funct_i == F_SUB ? ALU_SUB :
                    funct_i == F_AND ? ALU_AND :
                    funct_i == F_OR  ? ALU_OR  :
                    funct_i == F_SLT ? ALU_SLT : ALU_ADD;
    assign known = funct_i inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
    assign alucontrol_o = aluop_i == ALUOP_ADD ? ALU_ADD :
                          aluop_i == ALUOP_SUB ? ALU_SUB : fn_alu;
    assign illegal_o = aluop_i == ALUOP_FUNCT && !known;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS-style control FSM with memory wait timeout.
// Define MULTICYCLE_CONTROL_JUMP_EN to decode J into the JUMP state.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTL_W       = 3,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                iord,
    output logic                alusrca,
    output logic                irwrite,
    output logic                memwrite,
    output logic                regwrite,
    output logic                regdst,
    output logic                memtoreg,
    output logic                pcwrite,
    output logic                branch,
    output logic [1:0]          alusrcb,
    output logic [1:0]          pcsrc,
    output logic [ALUCTL_W-1:0] alucontrol,
    output logic                pc_en,
    output logic                illegal,
    output logic                mem_timeout
);
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] aluop;
    logic [2:0] dec_alu;
    logic       dec_ill, alu_use, ill_op, waiting, tmo;
    assign aluop = state_q == S_EXECUTE ? ALUOP_FUNCT :
                   state_q == S_BRANCH  ? ALUOP_SUB   : ALUOP_ADD;
    mc_alu_decoder u_dec (
        .aluop_i      (aluop),
        .funct_i      (funct),
        .alucontrol_o (dec_alu),
        .illegal_o    (dec_ill)
    );
    assign alucontrol = alu_use ? ALUCTL_W'(dec_alu) : '0;
    always_comb begin
        state_d  = state_q;
        iord     = 1'b0;
        alusrca  = 1'b0;
        irwrite  = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        alusrcb  = SRCB_REGB;
        pcsrc    = PCSRC_ALU;
        alu_use  = 1'b0;
        ill_op   = 1'b0;
        waiting  = 1'b0;
        case (state_q)
            S_FETCH: begin
                waiting = 1'b1;
                alusrcb = SRCB_FOUR;
                alu_use = 1'b1;
                irwrite = mem_ready;
                pcwrite = mem_ready;
                state_d = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb = SRCB_IMMSH;
                alu_use = 1'b1;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
                    OP_J:         state_d = S_JUMP;
`endif
                    default: begin
                        state_d = S_FETCH;
                        ill_op  = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                alu_use = 1'b1;
                state_d = opcode == OP_LW ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                waiting = 1'b1;
                iord    = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                waiting  = 1'b1;
                iord     = 1'b1;
                memwrite = mem_ready;
                state_d  = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                alu_use = 1'b1;
                state_d = dec_ill ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                alu_use = 1'b1;
                pcsrc   = PCSRC_ALUOUT;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                alu_use = 1'b1;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
`ifdef MULTICYCLE_CONTROL_JUMP_EN
            S_JUMP: begin
                pcsrc   = PCSRC_JUMP;
                pcwrite = 1'b1;
                state_d = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase
        // Abort the access when the wait budget runs out; a ready on the last cycle still completes.
        tmo = waiting && !mem_ready && cnt_q == 8'(TIMEOUT_CYCLES - 1);
        if (tmo) state_d = S_FETCH;
        cnt_d = waiting && !mem_ready && !tmo ? cnt_q + 8'd1 : 8'd0;
        if (reset) begin
            irwrite  = 1'b0;
            pcwrite  = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
        end
        pc_en       = pcwrite | (branch & zero & ~reset);
        illegal     = ~reset & (ill_op | (state_q == S_EXECUTE & dec_ill));
        mem_timeout = ~reset & tmo;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: per-instruction cycle-sequence reference model with random waits and opcodes.
module tb_multicycle_control;
    localparam int TMO = 4;
    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    typedef struct packed {
        logic iord, alusrca, irwrite, memwrite, regwrite, regdst, memtoreg, pcwrite, branch;
        logic [1:0] srcb, pcsrc;
        logic [3:0] alu;
        logic pc_en, ill, tmo;
    } ov_t;
    logic clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b0;
    logic [5:0] opcode = 6'd0, funct = 6'd0;
    logic iord, alusrca, irwrite, memwrite, regwrite, regdst, memtoreg, pcwrite, branch;
    logic pc_en, illegal, mem_timeout;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] alucontrol;
    ov_t obs;
    int n_chk = 0, n_fail = 0;
    logic [3:0] rtab [logic [5:0]];
    logic [5:0] ops [6] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    multicycle_control #(.ALUCTL_W(4), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .iord(iord), .alusrca(alusrca), .irwrite(irwrite),
        .memwrite(memwrite), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .pcwrite(pcwrite), .branch(branch), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .pc_en(pc_en), .illegal(illegal), .mem_timeout(mem_timeout)
    );
    always #5 clk = ~clk;
    assign obs = {iord, alusrca, irwrite, memwrite, regwrite, regdst, memtoreg, pcwrite, branch,
                  alusrcb, pcsrc, alucontrol, pc_en, illegal, mem_timeout};

    function automatic bit supported(input logic [5:0] op);
`ifdef MULTICYCLE_CONTROL_JUMP_EN
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
`else
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI};
`endif
    endfunction

    task automatic check(input ov_t e, input string tag);
        n_chk++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    task automatic step(input logic mr, input ov_t e, input string tag);
        mem_ready = mr;
        @(negedge clk);
        check(e, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input ov_t base, input ov_t rdy, input int w, input string tag, output bit ok);
        ov_t t;
        ok = 1'b1;
        for (int i = 0; i <= w; i++) begin
            if (i == w) begin
                step(1'b1, rdy, tag);
                return;
            end
            if (i == TMO - 1) begin
                t = base;
                t.tmo = 1'b1;
                step(1'b0, t, {tag, "_timeout"});
                ok = 1'b0;
                return;
            end
            step(1'b0, base, tag);
        end
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input int wf, input int wm);
        ov_t v, r;
        bit ok;
        logic any;
        opcode = op;
        funct = fn;
        zero = z;
        any = 1'($urandom_range(0, 1));
        v = '0; v.srcb = 2'b01; v.alu = 4'd2;
        r = v; r.irwrite = 1'b1; r.pcwrite = 1'b1; r.pc_en = 1'b1;
        wait_phase(v, r, wf, "fetch", ok);
        if (!ok) return;
        v = '0; v.srcb = 2'b11; v.alu = 4'd2; v.ill = !supported(op);
        step(any, v, "decode");
        if (v.ill) return;
        if (op == OP_LW || op == OP_SW) begin
            v = '0; v.alusrca = 1'b1; v.srcb = 2'b10; v.alu = 4'd2;
            step(any, v, "memadr");
            v = '0; v.iord = 1'b1;
            r = v; r.memwrite = op == OP_SW;
            wait_phase(v, r, wm, op == OP_LW ? "memrd" : "memwr", ok);
            if (!ok || op == OP_SW) return;
            v = '0; v.memtoreg = 1'b1; v.regwrite = 1'b1;
            step(any, v, "memwb");
        end else if (op == OP_RTYPE) begin
            v = '0; v.alusrca = 1'b1;
            v.ill = !rtab.exists(fn);
            v.alu = v.ill ? 4'd2 : rtab[fn];
            step(any, v, "execute");
            if (v.ill) return;
            v = '0; v.regdst = 1'b1; v.regwrite = 1'b1;
            step(any, v, "aluwb");
        end else if (op == OP_BEQ) begin
            v = '0; v.alusrca = 1'b1; v.alu = 4'd6; v.pcsrc = 2'b01; v.branch = 1'b1; v.pc_en = z;
            step(any, v, "branch");
        end else if (op == OP_ADDI) begin
            v = '0; v.alusrca = 1'b1; v.srcb = 2'b10; v.alu = 4'd2;
            step(any, v, "addiex");
            v = '0; v.regwrite = 1'b1;
            step(any, v, "addiwb");
        end else begin
            v = '0; v.pcsrc = 2'b10; v.pcwrite = 1'b1; v.pc_en = 1'b1;
            step(any, v, "jump");
        end
    endtask

    initial begin
        ov_t v;
        logic [5:0] op, fn;
        rtab[6'b100000] = 4'd2;
        rtab[6'b100010] = 4'd6;
        rtab[6'b100100] = 4'd0;
        rtab[6'b100101] = 4'd1;
        rtab[6'b101010] = 4'd7;
        mem_ready = 1'b1;
        @(negedge clk);
        v = '0; v.srcb = 2'b01; v.alu = 4'd2;
        check(v, "reset_outputs");
        @(posedge clk);
        #1 reset = 1'b0;
        instr(OP_LW, 6'd0, 1'b0, 0, 0);
        instr(OP_SW, 6'd0, 1'b1, 0, 0);
        for (int i = 0; i < 5; i++) instr(OP_RTYPE, fns[i], 1'b0, 0, 0);
        instr(OP_RTYPE, 6'b000000, 1'b0, 0, 0);
        instr(OP_BEQ, 6'd0, 1'b1, 0, 0);
        instr(OP_BEQ, 6'd0, 1'b0, 0, 0);
        instr(OP_ADDI, 6'd0, 1'b0, 0, 0);
        instr(OP_J, 6'd0, 1'b0, 0, 0);
        instr(6'b111111, 6'd0, 1'b0, 0, 0);
        instr(OP_LW, 6'd0, 1'b0, 0, 6);
        instr(OP_LW, 6'd0, 1'b0, 2, 3);
        instr(OP_SW, 6'd0, 1'b0, 3, 5);
        instr(OP_ADDI, 6'd0, 1'b0, 5, 0);
        opcode = OP_SW;
        v = '0; v.srcb = 2'b01; v.alu = 4'd2; v.irwrite = 1'b1; v.pcwrite = 1'b1; v.pc_en = 1'b1;
        step(1'b1, v, "rst_fetch");
        v = '0; v.srcb = 2'b11; v.alu = 4'd2;
        step(1'b1, v, "rst_decode");
        v = '0; v.alusrca = 1'b1; v.srcb = 2'b10; v.alu = 4'd2;
        step(1'b1, v, "rst_memadr");
        mem_ready = 1'b1;
        @(negedge clk);
        v = '0; v.iord = 1'b1; v.memwrite = 1'b1;
        check(v, "rst_memwr");
        #1 reset = 1'b1;
        #1;
        v = '0; v.srcb = 2'b01; v.alu = 4'd2;
        check(v, "rst_midmemwr");
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 80; k++) begin
            op = $urandom_range(0, 9) == 0 ? 6'($urandom) : ops[$urandom_range(0, 5)];
            fn = $urandom_range(0, 5) == 0 ? 6'($urandom) : fns[$urandom_range(0, 4)];
            instr(op, fn, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2) == 0 ? $urandom_range(0, 5) : 0,
                  $urandom_range(0, 2) == 0 ? $urandom_range(0, 5) : 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter ALUCTL_W, 3, ALU control width; SHALL be >=3; bits above [2] driven 0.
REQ-002 Parameter TIMEOUT_CYCLES, 15, maximum memory wait cycles before abort; range 1..255.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 opcode  input  6  instruction [31:26]; funct  input  6  instruction [5:0].
REQ-006 zero  input  1  ALU zero flag; mem_ready  input  1  memory access completes this cycle.
REQ-007 iord, alusrca, irwrite, memwrite, regwrite, regdst, memtoreg, pcwrite, branch  output  1 each  datapath controls.
REQ-008 alusrcb  output  2  00 regB, 01 const 4, 10 signext imm, 11 imm<<2; pcsrc  output  2  00 ALUResult, 01 ALUOut, 10 jump target.
REQ-009 alucontrol  output  ALUCTL_W  ALU op; pc_en  output  1  pcwrite | (branch & zero).
REQ-010 illegal  output  1  one-cycle pulse on unsupported opcode/funct; mem_timeout  output  1  one-cycle pulse on memory abort.

Function
REQ-011 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP; one transition per rising clk.
REQ-012 FETCH: iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, irwrite=pcwrite=mem_ready; hold until mem_ready, then DECODE.
REQ-013 DECODE: alusrca=0, alusrcb=11, alucontrol=010; next by opcode: 100011/101011->MEMADR, 000000->EXECUTE, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP, other->FETCH with illegal=1.
REQ-014 MEMADR: alusrca=1, alusrcb=10, alucontrol=010; LW->MEMRD, SW->MEMWR.
REQ-015 MEMRD: iord=1; hold until mem_ready, then MEMWB; MEMWB: regdst=0, memtoreg=1, regwrite=1, ->FETCH.
REQ-016 MEMWR: iord=1, memwrite=mem_ready; hold until mem_ready, then FETCH.
REQ-017 EXECUTE: alusrca=1, alusrcb=00, funct 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other->010 with illegal=1 and next FETCH; else ->ALUWB.
REQ-018 ALUWB: regdst=1, memtoreg=0, regwrite=1, ->FETCH.
REQ-019 BRANCH: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, branch=1, ->FETCH; pc_en equals zero.
REQ-020 ADDIEX: alusrca=1, alusrcb=10, alucontrol=010, ->ADDIWB; ADDIWB: regdst=0, memtoreg=0, regwrite=1, ->FETCH.
REQ-021 JUMP: pcsrc=10, pcwrite=1, ->FETCH.
REQ-022 Every output not listed for a state SHALL be 0 (no X drive); outputs decode combinationally from state, opcode, funct, zero, mem_ready.
REQ-023 Wait counter SHALL clear on entry to FETCH/MEMRD/MEMWR and increment each cycle mem_ready=0 there; reaching TIMEOUT_CYCLES with mem_ready=0 SHALL pulse mem_timeout, suppress all writes, go to FETCH.
REQ-024 mem_ready=1 on the cycle counter reaches TIMEOUT_CYCLES SHALL complete the access normally (ready wins).
REQ-025 Latencies with mem_ready always 1: LW 5, SW 4, R-type 4, BEQ 3, ADDI 4, J 3 cycles.

Reset
REQ-026 reset high SHALL force state FETCH and counter 0 immediately; while high irwrite, pcwrite, pc_en, memwrite, regwrite, illegal, mem_timeout SHALL be 0.
REQ-027 Reset mid-instruction SHALL abandon it; first fetch on first rising clk after deassertion.

Configuration
REQ-028 Macro MULTICYCLE_CONTROL_JUMP_EN defined: J (000010) decodes to JUMP per REQ-021.
REQ-029 Macro undefined: JUMP state absent, J treated as illegal opcode (REQ-013), pcsrc never 10.

Structure
REQ-030 Shared package mc_ctrl_pkg SHALL hold opcode/funct constants, state enum, ALU control codes, alusrcb/pcsrc encodings.
REQ-031 ALU decoder (ALUOp+funct -> alucontrol, illegal) SHALL be sub-module mc_alu_decoder; FSM and counter stay in top.

Verification
REQ-032 LW, mem_ready=1: states FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite=1, memtoreg=1 only in cycle 5.
REQ-033 BEQ zero=1 -> pc_en=1, pcsrc=01 in cycle 3; zero=0 -> pc_en=0.
REQ-034 R-type funct 101010 -> alucontrol=111 in EXECUTE; funct 000000 -> illegal pulse, no regwrite, back to FETCH.
REQ-035 mem_ready held 0 in MEMRD, TIMEOUT_CYCLES=4 -> mem_timeout=1 on 4th wait cycle, next state FETCH, no regwrite.
REQ-036 Opcode 000010: with macro -> pcwrite=1, pcsrc=10 in cycle 3; without -> illegal in DECODE.
REQ-037 reset asserted during MEMWR between edges -> memwrite drops immediately, state FETCH.
